// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: a single CPU request port served by RAM (with a
// configurable wait), a GPIO port and a free-running counter.
module mio_responder #(
    parameter int RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mio,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr_bus,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] REGION_RAM  = 2'd0;
    localparam logic [1:0] REGION_GPIO = 2'd1;
    localparam logic [1:0] REGION_CNT  = 2'd2;
    localparam logic [1:0] REGION_NONE = 2'd3;
    localparam logic [2:0] WAIT_LAST   = 3'(RAM_WAIT - 1);

    function automatic logic [1:0] decode_region(input logic [3:0] page);
        case (page)
            4'h0:    decode_region = REGION_RAM;
            4'hE:    decode_region = REGION_GPIO;
            4'hF:    decode_region = REGION_CNT;
            default: decode_region = REGION_NONE;
        endcase
    endfunction

    state_t      state_r;
    logic [9:0]  word_addr_r;
    logic [31:0] wdata_r;
    logic        write_r;
    logic [2:0]  wait_cnt_r;
    logic [31:0] rdata_r;
    logic        mio_ready_r;
    logic        ram_we_r;
    logic [31:0] gpio_out_r;
    logic [31:0] counter_r;

    logic        accept_s;
    logic [1:0]  req_region_s;
    logic        counter_wr_s;
    logic        unused_s;

    // Request qualification and decode of the incoming (not yet latched) address.
    always_comb begin
        accept_s     = (state_r == IDLE) && cpu_mio && (mem_r || mem_w);
        req_region_s = decode_region(addr_bus[31:28]);
        // mem_w alone selects a write, so a simultaneous mem_r is ignored.
        counter_wr_s = accept_s && mem_w && (req_region_s == REGION_CNT);
    end

    assign unused_s = ^{addr_bus[27:12], addr_bus[1:0]};

    // Free-running counter; a CPU write overrides the increment for that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_r <= 32'h0000_0000;
        end else if (counter_wr_s) begin
            counter_r <= wdata;
        end else begin
            counter_r <= counter_r + 32'd1;
        end
    end

    // Transaction FSM with all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            word_addr_r <= 10'd0;
            wdata_r     <= 32'h0000_0000;
            write_r     <= 1'b0;
            wait_cnt_r  <= 3'd0;
            rdata_r     <= 32'h0000_0000;
            mio_ready_r <= 1'b0;
            ram_we_r    <= 1'b0;
            gpio_out_r  <= 32'h0000_0000;
        end else begin
            mio_ready_r <= 1'b0;
            ram_we_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        word_addr_r <= addr_bus[11:2];
                        wdata_r     <= wdata;
                        write_r     <= mem_w;
                        if (req_region_s == REGION_RAM) begin
                            state_r    <= WAIT;
                            wait_cnt_r <= 3'd0;
                            ram_we_r   <= mem_w;
                        end else begin
                            state_r     <= ACK;
                            mio_ready_r <= 1'b1;
                            case (req_region_s)
                                REGION_GPIO: begin
                                    if (mem_w) begin
                                        gpio_out_r <= wdata;
                                    end else begin
                                        rdata_r <= gpio_in;
                                    end
                                end
                                REGION_CNT: begin
                                    if (!mem_w) begin
                                        rdata_r <= counter_r;
                                    end
                                end
                                default: begin
                                    if (!mem_w) begin
                                        rdata_r <= 32'h0000_0000;
                                    end
                                end
                            endcase
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r     <= ACK;
                        mio_ready_r <= 1'b1;
                        if (!write_r) begin
                            rdata_r <= ram_dout;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rdata     = rdata_r;
    assign mio_ready = mio_ready_r;
    assign ram_addr  = word_addr_r;
    assign ram_din   = wdata_r;
    assign ram_we    = ram_we_r;
    assign gpio_out  = gpio_out_r;

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench for mio_responder: two instances (RAM_WAIT=1 and RAM_WAIT=3),
// each with a synchronous RAM model; expected responses queued at issue time.
module tb_mio_responder;

    typedef struct {
        int          dut;
        int          acc;
        int          lat;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          ramw;
        logic [9:0]  waddr;
        logic [31:0] wdin;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio   [2];
    logic        mem_r     [2];
    logic        mem_w     [2];
    logic [31:0] addr_bus  [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic        mio_ready [2];
    logic [9:0]  ram_addr  [2];
    logic [31:0] ram_din   [2];
    logic        ram_we    [2];
    logic [31:0] ram_dout  [2];
    logic [31:0] gpio_in   [2];
    logic [31:0] gpio_out  [2];

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    exp_t sbq[$];
    exp_t e;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   we_seen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mio_responder #(.RAM_WAIT(1)) u_dut_w1 (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio[0]), .mem_r(mem_r[0]), .mem_w(mem_w[0]),
        .addr_bus(addr_bus[0]), .wdata(wdata[0]), .rdata(rdata[0]), .mio_ready(mio_ready[0]),
        .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_we(ram_we[0]), .ram_dout(ram_dout[0]),
        .gpio_in(gpio_in[0]), .gpio_out(gpio_out[0])
    );

    mio_responder #(.RAM_WAIT(3)) u_dut_w3 (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio[1]), .mem_r(mem_r[1]), .mem_w(mem_w[1]),
        .addr_bus(addr_bus[1]), .wdata(wdata[1]), .rdata(rdata[1]), .mio_ready(mio_ready[1]),
        .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_we(ram_we[1]), .ram_dout(ram_dout[1]),
        .gpio_in(gpio_in[1]), .gpio_out(gpio_out[1])
    );

    // Synchronous RAM models: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (ram_we[0]) mem0[ram_addr[0]] <= ram_din[0];
        ram_dout[0] <= mem0[ram_addr[0]];
        if (ram_we[1]) mem1[ram_addr[1]] <= ram_din[1];
        ram_dout[1] <= mem1[ram_addr[1]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: match every ram_we and mio_ready against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (ram_we[d]) begin
                    if (sbq.size() != 0 && sbq[0].dut == d && sbq[0].ramw) begin
                        chk({sbq[0].name, " we cycle"}, 32'(cyc), 32'(sbq[0].acc));
                        chk({sbq[0].name, " ram_addr"}, {22'd0, ram_addr[d]}, {22'd0, sbq[0].waddr});
                        chk({sbq[0].name, " ram_din"}, ram_din[d], sbq[0].wdin);
                        we_seen++;
                    end else begin
                        chk("unexpected ram_we", {31'd0, ram_we[d]}, 32'd0);
                    end
                end
                if (mio_ready[d]) begin
                    if (sbq.size() != 0 && sbq[0].dut == d) begin
                        e = sbq.pop_front();
                        chk({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                        if (e.chk_rd) chk({e.name, " rdata"}, rdata[d], e.exp_rd);
                        if (e.ramw) chk({e.name, " we count"}, 32'(we_seen), 32'd1);
                        we_seen = 0;
                    end else begin
                        chk("unexpected mio_ready", {31'd0, mio_ready[d]}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input bit chk_rd, input logic [31:0] exp_rd,
                         input int lat, input string name, input int gap, input bit wait_done);
        exp_t x;
        bit   seen;
        repeat (gap) @(negedge clk);
        cpu_mio[d]  = 1'b1;
        mem_r[d]    = r;
        mem_w[d]    = w;
        addr_bus[d] = a;
        wdata[d]    = wd;
        x.dut    = d;
        x.acc    = cyc + 1;
        x.lat    = lat;
        x.chk_rd = chk_rd;
        x.exp_rd = exp_rd;
        x.ramw   = w && (a[31:28] == 4'h0);
        x.waddr  = a[11:2];
        x.wdin   = wd;
        x.name   = name;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        // Scramble the bus so any use of unlatched inputs shows up.
        cpu_mio[d]  = 1'b0;
        mem_r[d]    = ~r;
        mem_w[d]    = ~w;
        addr_bus[d] = ~a;
        wdata[d]    = ~wd;
        if (wait_done) begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mio_ready[d]) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk({name, " completed"}, {31'd0, seen}, 32'd1);
        end
    endtask

    initial begin
        logic any_act;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cpu_mio[d] = 1'b0; mem_r[d] = 1'b0; mem_w[d] = 1'b0;
            addr_bus[d] = 32'h0; wdata[d] = 32'h0; gpio_in[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset rdata", rdata[d], 32'h0);
            chk("reset mio_ready", {31'd0, mio_ready[d]}, 32'd0);
            chk("reset ram_we", {31'd0, ram_we[d]}, 32'd0);
            chk("reset gpio_out", gpio_out[d], 32'h0);
        end
        reset = 1'b0;

        // RAM_WAIT=1 instance
        issue(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0, 2, "w1 ram wr", 1, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678, 2, "w1 ram rd", 1, 1'b1);
        issue(0, 1'b0, 1'b1, 32'hE000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0, 1, "gpio wr", 1, 1'b1);
        chk("gpio_out after wr", gpio_out[0], 32'hA5A5_A5A5);
        gpio_in[0] = 32'h0000_BEEF;
        issue(0, 1'b1, 1'b0, 32'hE000_0004, 32'h0, 1'b1, 32'h0000_BEEF, 1, "gpio rd", 1, 1'b1);
        issue(0, 1'b1, 1'b1, 32'hE000_0000, 32'h5A5A_0001, 1'b0, 32'h0, 1, "rw both", 1, 1'b1);
        chk("rw both gpio_out", gpio_out[0], 32'h5A5A_0001);
        chk("rw both rdata held", rdata[0], 32'h0000_BEEF);
        issue(0, 1'b0, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1, "unmapped wr", 1, 1'b1);
        chk("unmapped wr gpio_out", gpio_out[0], 32'h5A5A_0001);
        chk("unmapped wr rdata held", rdata[0], 32'h0000_BEEF);
        issue(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b1, 32'h0, 1, "unmapped rd", 1, 1'b1);
        issue(0, 1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 1'b0, 32'h0, 1, "cnt wr", 1, 1'b1);
        issue(0, 1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b1, 32'h0000_0001, 1, "cnt rd wrap", 3, 1'b1);

        // RAM_WAIT=3 instance
        issue(1, 1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0, 4, "w3 ram wr", 1, 1'b1);
        issue(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'hCAFE_F00D, 4, "w3 ram rd", 1, 1'b1);
        issue(1, 1'b0, 1'b1, 32'hE000_0000, 32'h1111_2222, 1'b0, 32'h0, 1, "w3 gpio wr", 1, 1'b1);
        gpio_in[1] = 32'h00C0_FFEE;
        issue(1, 1'b1, 1'b0, 32'hE000_0008, 32'h0, 1'b1, 32'h00C0_FFEE, 1, "w3 gpio rd", 1, 1'b1);

        // Abort a RAM write in its second WAIT cycle.
        issue(1, 1'b0, 1'b1, 32'h0000_0020, 32'h7777_7777, 1'b0, 32'h0, 4, "aborted wr", 1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        we_seen = 0;
        #1;
        chk("abort mio_ready", {31'd0, mio_ready[1]}, 32'd0);
        chk("abort ram_we", {31'd0, ram_we[1]}, 32'd0);
        chk("abort rdata", rdata[1], 32'h0);
        chk("abort gpio_out", gpio_out[1], 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        any_act = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_act = any_act | mio_ready[1] | ram_we[1];
        end
        chk("no activity after abort", {31'd0, any_act}, 32'd0);
        issue(1, 1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b1, 32'h0000_0007, 1, "cnt after reset", 1, 1'b1);
        issue(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'hCAFE_F00D, 4, "ram rd after abort", 1, 1'b1);

        // Request accepted on the very first edge after reset release.
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(1, 1'b1, 1'b0, 32'hF000_0000, 32'h0, 1'b1, 32'h0000_0000, 1, "first edge rd", 0, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
